// File: rtl/e203_itcm_ram_sched_if.sv
// Requester channel between a core port (IFU or LSU) and the ITCM scheduler:
// one command handshake plus one response handshake.
interface e203_itcm_ram_sched_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 64,
  parameter int unsigned MW = 8
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/e203_itcm_ram_sched.sv
// ITCM RAM scheduler: round-robin arbitration of IFU/LSU onto a single-port
// RAM with 1-cycle read latency, one outstanding response, and an idle-driven
// light-sleep request that costs one wake cycle.
module e203_itcm_ram_sched #(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 64,
  parameter int unsigned MW       = 8,
  parameter int unsigned IDLE_CNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  e203_itcm_ram_sched_if.slave  ifu,
  e203_itcm_ram_sched_if.slave  lsu,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [MW-1:0]         ram_wem,
  output logic [DW-1:0]         ram_din,
  input  logic [DW-1:0]         ram_dout,
  output logic                  ram_ls
);

  localparam logic [7:0] IdleMax = 8'(IDLE_CNT);

  typedef enum logic {StActive, StSleep} pwr_e;

  pwr_e          pwr_q, pwr_d;
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic          out_vld_q, out_vld_d;
  logic          out_lsu_q, out_lsu_d;
  logic          out_read_q, out_read_d;
  logic          hold_vld_q, hold_vld_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          last_lsu_q, last_lsu_d;

  logic          any_valid;
  logic          rsp_fire;
  logic          can_issue;
  logic          pick_lsu, pick_ifu;
  logic          fire_lsu, fire_ifu, fire;
  logic          sel_read;
  logic [DW-1:0] rsp_data;

  // Arbitration, cmd_ready and RAM request; ready never depends on ram_dout.
  always_comb begin
    any_valid = ifu.cmd_valid | lsu.cmd_valid;
    rsp_fire  = out_vld_q & (out_lsu_q ? lsu.rsp_ready : ifu.rsp_ready);
    can_issue = (pwr_q == StActive) & (~out_vld_q | rsp_fire);
    // LSU wins a tie unless it was the last one granted.
    pick_lsu  = lsu.cmd_valid & (~ifu.cmd_valid | ~last_lsu_q);
    pick_ifu  = ifu.cmd_valid & ~pick_lsu;
    ifu.cmd_ready = can_issue & ~pick_lsu;
    lsu.cmd_ready = can_issue & ~pick_ifu;
    fire_lsu  = can_issue & pick_lsu;
    fire_ifu  = can_issue & pick_ifu;
    fire      = fire_lsu | fire_ifu;
    sel_read  = fire_lsu ? lsu.cmd_read : ifu.cmd_read;

    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (fire_lsu) begin
      ram_cs   = 1'b1;
      ram_we   = ~lsu.cmd_read;
      ram_addr = lsu.cmd_addr;
      ram_wem  = lsu.cmd_wmask;
      ram_din  = lsu.cmd_wdata;
    end else if (fire_ifu) begin
      ram_cs   = 1'b1;
      ram_we   = ~ifu.cmd_read;
      ram_addr = ifu.cmd_addr;
      ram_wem  = ifu.cmd_wmask;
      ram_din  = ifu.cmd_wdata;
    end
  end

  // Response path: live RAM data on the first response cycle, held data after a stall.
  always_comb begin
    rsp_data      = ~out_read_q ? '0 : (hold_vld_q ? hold_data_q : ram_dout);
    ifu.rsp_valid = out_vld_q & ~out_lsu_q;
    lsu.rsp_valid = out_vld_q & out_lsu_q;
    ifu.rsp_rdata = ifu.rsp_valid ? rsp_data : '0;
    lsu.rsp_rdata = lsu.rsp_valid ? rsp_data : '0;
    ram_ls        = (pwr_q == StSleep);
  end

  // Next state: outstanding tracking, RR pointer, idle counter and sleep FSM.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_lsu_d   = out_lsu_q;
    out_read_d  = out_read_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    last_lsu_d  = last_lsu_q;
    idle_cnt_d  = idle_cnt_q;
    pwr_d       = pwr_q;

    if (rsp_fire) begin
      out_vld_d  = 1'b0;
      hold_vld_d = 1'b0;
    end else if (out_vld_q && !hold_vld_q) begin
      // Stalled response: freeze RAM output before it changes.
      hold_vld_d  = 1'b1;
      hold_data_d = rsp_data;
    end

    if (fire) begin
      out_vld_d  = 1'b1;
      out_lsu_d  = fire_lsu;
      out_read_d = sel_read;
      last_lsu_d = fire_lsu;
    end

    if (fire) begin
      idle_cnt_d = '0;
    end else if (!out_vld_q && idle_cnt_q < IdleMax) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end

    unique case (pwr_q)
      StActive: if (idle_cnt_d == IdleMax) pwr_d = StSleep;
      StSleep: begin
        if (any_valid) begin
          pwr_d      = StActive;
          idle_cnt_d = '0;
        end
      end
    endcase
  end

  // State registers; reset drops any outstanding response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q       <= StActive;
      idle_cnt_q  <= '0;
      out_vld_q   <= 1'b0;
      out_lsu_q   <= 1'b0;
      out_read_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      last_lsu_q  <= 1'b0;
    end else begin
      pwr_q       <= pwr_d;
      idle_cnt_q  <= idle_cnt_d;
      out_vld_q   <= out_vld_d;
      out_lsu_q   <= out_lsu_d;
      out_read_q  <= out_read_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      last_lsu_q  <= last_lsu_d;
    end
  end

endmodule

// File: tb/tb_e203_itcm_ram_sched.sv
// Scoreboard bench for e203_itcm_ram_sched: stimulus pushes expected read data
// per requester, a negedge monitor pops and compares on every response handshake.
module tb_e203_itcm_ram_sched;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  e203_itcm_ram_sched_if #(.AW(AW), .DW(DW), .MW(MW)) ifu_if ();
  e203_itcm_ram_sched_if #(.AW(AW), .DW(DW), .MW(MW)) lsu_if ();

  logic          ram_cs, ram_we, ram_ls;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  e203_itcm_ram_sched #(.AW(AW), .DW(DW), .MW(MW), .IDLE_CNT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifu      (ifu_if.slave),
    .lsu      (lsu_if.slave),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_ls   (ram_ls)
  );

  function automatic logic [63:0] init_word(input int a);
    logic [31:0] hi, lo;
    hi = 32'hC0DE_0000 + 32'(a);
    lo = 32'h5EED_0000 + 32'(a * 3);
    return {hi, lo};
  endfunction

  // RAM model: 1-cycle read latency, junk on dout whenever no read was issued.
  logic [63:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
  always @(posedge clk) begin
    if (ram_cs && !ram_we) begin
      ram_dout <= mem[ram_addr[7:0]];
    end else begin
      ram_dout <= {$urandom, $urandom};
      if (ram_cs) begin
        for (int b = 0; b < 8; b++)
          if (ram_wem[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  logic [63:0] exp_ifu[$];
  logic [63:0] exp_lsu[$];
  int          rsp_cyc_ifu = -1;
  int          rsp_cyc_lsu = -1;
  bit          wr_seen = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_wem;
  logic [DW-1:0] wr_din;

  // Monitor: compare every response handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifu_if.rsp_valid && ifu_if.rsp_ready) begin
        chk("ifu rsp expected", 64'(exp_ifu.size() > 0), 64'(1));
        if (exp_ifu.size() > 0) chk("ifu rdata", ifu_if.rsp_rdata, exp_ifu.pop_front());
        rsp_cyc_ifu = cyc;
      end
      if (lsu_if.rsp_valid && lsu_if.rsp_ready) begin
        chk("lsu rsp expected", 64'(exp_lsu.size() > 0), 64'(1));
        if (exp_lsu.size() > 0) chk("lsu rdata", lsu_if.rsp_rdata, exp_lsu.pop_front());
        rsp_cyc_lsu = cyc;
      end
      if (!ram_cs)
        chk("ram outputs idle", 64'(ram_we | (|ram_addr) | (|ram_wem) | (|ram_din)), 64'(0));
      if (ram_cs && ram_we) begin
        wr_seen = 1'b1;
        wr_addr = ram_addr;
        wr_wem  = ram_wem;
        wr_din  = ram_din;
      end
    end
  end

  // Drive one command (p=1 lsu) until it fires; optionally queue its response.
  task automatic issue(input string nm, input bit p, input bit rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                       input logic [DW-1:0] exp, input bit want_rsp, output int fcyc);
    bit done = 1'b0;
    fcyc = -1;
    if (p) begin
      lsu_if.cmd_valid = 1'b1; lsu_if.cmd_read = rd; lsu_if.cmd_addr = a;
      lsu_if.cmd_wdata = wd;   lsu_if.cmd_wmask = wm;
    end else begin
      ifu_if.cmd_valid = 1'b1; ifu_if.cmd_read = rd; ifu_if.cmd_addr = a;
      ifu_if.cmd_wdata = wd;   ifu_if.cmd_wmask = wm;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (p ? (lsu_if.cmd_valid && lsu_if.cmd_ready) : (ifu_if.cmd_valid && ifu_if.cmd_ready))
      begin
        done = 1'b1;
        fcyc = cyc;
        if (want_rsp) begin
          if (p) exp_lsu.push_back(exp);
          else   exp_ifu.push_back(exp);
        end
      end
    end
    chk({nm, " fired in time"}, 64'(done), 64'(1));
    @(posedge clk); #1;
    if (p) lsu_if.cmd_valid = 1'b0;
    else   ifu_if.cmd_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset ifu rsp_valid", 64'(ifu_if.rsp_valid), 64'(0));
    chk("reset lsu rsp_valid", 64'(lsu_if.rsp_valid), 64'(0));
    chk("reset ram_ls", 64'(ram_ls), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f_l, f_i, f, f2, w;
    logic [63:0] w5;
    ifu_if.cmd_valid = 0; ifu_if.cmd_read = 0; ifu_if.cmd_addr = '0;
    ifu_if.cmd_wdata = '0; ifu_if.cmd_wmask = '0; ifu_if.rsp_ready = 1;
    lsu_if.cmd_valid = 0; lsu_if.cmd_read = 0; lsu_if.cmd_addr = '0;
    lsu_if.cmd_wdata = '0; lsu_if.cmd_wmask = '0; lsu_if.rsp_ready = 1;
    @(posedge clk); #1;
    reset_dut();

    // Tie after reset: LSU first, IFU next cycle.
    c0 = cyc;
    fork
      issue("lsu rd 0x10", 1'b1, 1'b1, 13'h10, '0, '0, init_word(16), 1'b1, f_l);
      issue("ifu rd 0x20", 1'b0, 1'b1, 13'h20, '0, '0, init_word(32), 1'b1, f_i);
    join
    chk("tie lsu fire cycle", 64'(f_l), 64'(c0));
    chk("tie ifu fire cycle", 64'(f_i), 64'(c0 + 1));
    repeat (2) @(posedge clk); #1;
    chk("lsu rsp cycle", 64'(rsp_cyc_lsu), 64'(c0 + 1));
    chk("ifu rsp cycle", 64'(rsp_cyc_ifu), 64'(c0 + 2));

    // Masked write then read back.
    w5 = init_word(5);
    issue("lsu wr 5", 1'b1, 1'b0, 13'h5, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F, 64'h0, 1'b1, f);
    chk("write seen on ram_we", 64'(wr_seen), 64'(1));
    chk("write ram_addr", 64'(wr_addr), 64'h5);
    chk("write ram_wem", 64'(wr_wem), 64'h0F);
    chk("write ram_din", wr_din, 64'hA5A5_A5A5_A5A5_A5A5);
    issue("lsu rd 5", 1'b1, 1'b1, 13'h5, '0, '0, {w5[63:32], 32'hA5A5_A5A5}, 1'b1, f2);
    chk("back-to-back fire", 64'(f2), 64'(f + 1));

    // Stalled IFU response holds data and blocks both requesters.
    ifu_if.rsp_ready = 1'b0;
    issue("ifu rd 0x30", 1'b0, 1'b1, 13'h30, '0, '0, init_word(48), 1'b1, f);
    fork
      issue("lsu rd 0x31", 1'b1, 1'b1, 13'h31, '0, '0, init_word(49), 1'b1, f2);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall rsp_valid", 64'(ifu_if.rsp_valid), 64'(1));
          chk("stall rdata", ifu_if.rsp_rdata, init_word(48));
          chk("stall ifu cmd_ready", 64'(ifu_if.cmd_ready), 64'(0));
          chk("stall lsu cmd_ready", 64'(lsu_if.cmd_ready), 64'(0));
        end
        @(posedge clk); #1;
        ifu_if.rsp_ready = 1'b1;
      end
    join
    chk("fire on rsp_ready", 64'(f2), 64'(f + 4));
    repeat (3) @(posedge clk); #1;
    chk("queues drained", 64'(exp_ifu.size() + exp_lsu.size()), 64'(0));

    // Light sleep after 16 idle cycles and one-cycle wake.
    reset_dut();
    repeat (16) @(negedge clk);
    chk("ls low at 15 idle", 64'(ram_ls), 64'(0));
    @(negedge clk);
    chk("ls high at 16 idle", 64'(ram_ls), 64'(1));
    @(posedge clk); #1;
    w = cyc;
    fork
      issue("ifu wake rd 0x40", 1'b0, 1'b1, 13'h40, '0, '0, init_word(64), 1'b1, f);
      begin
        @(negedge clk);
        chk("wake cmd_ready", 64'(ifu_if.cmd_ready), 64'(0));
        chk("wake ls still high", 64'(ram_ls), 64'(1));
        @(negedge clk);
        chk("ls fallen", 64'(ram_ls), 64'(0));
      end
    join
    chk("wake fire cycle", 64'(f), 64'(w + 1));
    repeat (17) @(negedge clk);
    chk("idle restart ls low", 64'(ram_ls), 64'(0));
    @(negedge clk);
    chk("idle restart ls high", 64'(ram_ls), 64'(1));

    // Reset one cycle after a fire drops the response and the RR pointer.
    @(posedge clk); #1;
    issue("lsu rd 0x50", 1'b1, 1'b1, 13'h50, '0, '0, '0, 1'b0, f);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rsp killed by reset", 64'(lsu_if.rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no rsp after reset", 64'(lsu_if.rsp_valid | ifu_if.rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    c0 = cyc;
    fork
      issue("lsu rd 0x61", 1'b1, 1'b1, 13'h61, '0, '0, init_word(97), 1'b1, f_l);
      issue("ifu rd 0x60", 1'b0, 1'b1, 13'h60, '0, '0, init_word(96), 1'b1, f_i);
    join
    chk("post-reset tie lsu", 64'(f_l), 64'(c0));
    chk("post-reset tie ifu", 64'(f_i), 64'(c0 + 1));
    repeat (3) @(posedge clk); #1;
    chk("final queues drained", 64'(exp_ifu.size() + exp_lsu.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/e203_itcm_ram_sched.md
E203_ITCM_RAM_SCHED -- requirements
Module: e203_itcm_ram_sched

Interface
REQ-001 SHALL have parameter AW, default 13, meaning RAM word-address width.
REQ-002 SHALL have parameter DW, default 64, meaning RAM data width.
REQ-003 SHALL have parameter MW, default 8, meaning write-mask width (DW/8).
REQ-004 SHALL have parameter IDLE_CNT, default 16, meaning idle cycles before light-sleep (range 2..255).
REQ-005 SHALL have port clk, input, 1, meaning single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have, for each requester p in {ifu, lsu}, port p_cmd_valid, input, 1, meaning command request.
REQ-008 SHALL have port p_cmd_ready, output, 1, meaning command accepted this cycle.
REQ-009 SHALL have port p_cmd_read, input, 1, meaning 1=read, 0=write.
REQ-010 SHALL have port p_cmd_addr, input, AW, meaning word address.
REQ-011 SHALL have ports p_cmd_wdata, input, DW, and p_cmd_wmask, input, MW, meaning write data and byte mask.
REQ-012 SHALL have ports p_rsp_valid, output, 1; p_rsp_ready, input, 1; p_rsp_rdata, output, DW, meaning response handshake and read data.
REQ-013 SHALL have RAM-side ports ram_cs, ram_we, ram_addr (AW), ram_wem (MW) and ram_din (DW) as outputs; ram_dout (DW) as input; ram_ls (1) as output, meaning light-sleep request.

Function
REQ-014 SHALL grant at most one command per cycle; a command fires when cmd_valid & cmd_ready.
REQ-015 SHALL arbitrate round-robin: when both are valid, grant the requester not granted last; the pointer updates only on a fire.
REQ-016 SHALL drive ram_cs=1 in the fire cycle, with ram_we=!cmd_read, and ram_addr/ram_wem/ram_din taken from the winner; all RAM outputs SHALL be 0 otherwise.
REQ-017 SHALL assert the winner's rsp_valid exactly 1 cycle after the fire (latency 1); rdata=ram_dout for reads and 0 for writes.
REQ-018 SHALL track one outstanding response (owner and read flag); when rsp_valid & !rsp_ready, rdata SHALL be captured into a hold register and presented stably until rsp_ready.
REQ-019 SHALL deassert both cmd_ready while a response is outstanding and not firing this cycle; back-to-back fire SHALL be allowed when the response fires in the same cycle.
REQ-020 SHALL deassert the non-winner's cmd_ready in a contended cycle; the loser's valid SHALL remain pending without loss.
REQ-021 SHALL increment an 8-bit idle counter each cycle without ram_cs and no outstanding response, saturating at IDLE_CNT; any ram_cs SHALL clear it.
REQ-022 SHALL set ram_ls=1 when the counter reaches IDLE_CNT.
REQ-023 SHALL, while ram_ls=1 and any cmd_valid is high, clear ram_ls on the next edge and hold all cmd_ready=0 for that wake cycle; commands fire no earlier than the cycle after ram_ls falls.
REQ-024 SHALL treat cmd_ready as combinational from valids, state and rsp_ready only; there SHALL be no combinational path from ram_dout to any ready.

Reset
REQ-025 SHALL, while rst_n=0, force rsp_valid=0, ram_ls=0, idle counter=0, the outstanding flag clear and the RR pointer to "last=ifu" (LSU wins the first tie).
REQ-026 SHALL discard any outstanding response on reset mid-transaction; no rsp_valid SHALL appear after release without a new fire.

Verification
REQ-027 SHALL cover: after reset, both valid, reads at addr 0x10 (lsu) and 0x20 (ifu), rsp_ready=1 -> lsu fires in cycle 0, ifu in cycle 1, responses in cycles 1 and 2 with the data stored at each address.
REQ-028 SHALL cover: lsu write addr 5, wdata 0xA5A5_A5A5_A5A5_A5A5, wmask 0x0F, then read addr 5 -> ram_we=1, ram_wem=0x0F, write rsp rdata=0, and the read returns the low 4 bytes updated.
REQ-029 SHALL cover: ifu read with rsp_ready=0 for 3 cycles -> rdata stable for all 3 cycles, both cmd_ready=0 throughout, and a new fire in the cycle rsp_ready=1.
REQ-030 SHALL cover: 16 idle cycles -> ram_ls=1; then ifu valid -> one cycle with cmd_ready=0 and ram_ls falling, fire on the next cycle, and the idle counter reset to 0.
REQ-031 SHALL cover: rst_n pulsed low one cycle after a fire -> no rsp_valid after release; RR favors lsu on the next tie.
